// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: round-robin sharing of one down-counting delay timer among NREQ requesters.
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   req        per-requester level request, held until done or abandoned
//   req_len    per-requester delay length, slice i = [i*WIDTH +: WIDTH]
//   hold       (only with SHARED_TIMER_HOLD_EN) freezes the countdown while high
//   gnt        registered one-hot grant
//   done       registered one-cycle completion pulse to the granted requester
//   busy       high whenever the arbiter is not idle
//   active_id  index of the granted requester
//   count      current counter value
// Optional feature macro: SHARED_TIMER_HOLD_EN
module shared_timer_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_len,
`ifdef SHARED_TIMER_HOLD_EN
   input  logic                  hold,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [IDW-1:0]        active_id,
   output logic [WIDTH-1:0]      count
);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, COUNT = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic [IDW-1:0] ptr, win;
   logic frz;
`ifdef SHARED_TIMER_HOLD_EN
   assign frz = hold;
`else
   assign frz = 1'b0;
`endif
   assign busy = state != IDLE;
   // Scan from the farthest candidate to the nearest so the last hit is the
   // first set bit after the pointer, giving round-robin priority.
   always_comb begin
      win = '0;
      for (int k = NREQ; k >= 1; k--)
         if (req[(int'(ptr) + k) % NREQ]) win = IDW'((int'(ptr) + k) % NREQ);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt <= '0;
         done <= '0;
         active_id <= '0;
         count <= '0;
         ptr <= IDW'(NREQ - 1);
      end else begin
         done <= '0;
         case (state)
            IDLE: if (|req) begin
               gnt <= NREQ'(1) << win;
               active_id <= win;
               ptr <= win;
               state <= LOAD;
            end
            LOAD: if (!req[active_id]) begin
               gnt <= '0;
               state <= IDLE;
            end else begin
               count <= req_len[active_id*WIDTH +: WIDTH];
               state <= COUNT;
            end
            // Abort wins over completion; an abandoned request never sees done.
            COUNT: if (!req[active_id]) begin
               gnt <= '0;
               state <= IDLE;
            end else if (!frz) begin
               if (count == '0) begin
                  done <= gnt;
                  state <= DONE;
               end else count <= count - 1'b1;
            end
            DONE: begin
               gnt <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// tb_shared_timer_arbiter: directed scoreboard bench for shared_timer_arbiter.
module tb_shared_timer_arbiter;
   localparam int WIDTH = 8;
   localparam int NREQ = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ*WIDTH-1:0] req_len = '0;
`ifdef SHARED_TIMER_HOLD_EN
   logic hold = 1'b0;
`endif
   logic [NREQ-1:0] gnt, done;
   logic busy;
   logic [1:0] active_id;
   logic [WIDTH-1:0] count;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   typedef struct {int id; int at;} exp_t;
   exp_t sb[$];

   shared_timer_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_len(req_len),
`ifdef SHARED_TIMER_HOLD_EN
      .hold(hold),
`endif
      .gnt(gnt),
      .done(done),
      .busy(busy),
      .active_id(active_id),
      .count(count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int i, input int l);
      req_len[i*WIDTH +: WIDTH] = WIDTH'(l);
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      e = sb.pop_front();
      for (int k = 0; k < 200; k++) begin
         step();
         if (done != '0) break;
      end
      chk({tag, " done"}, 32'(done), 32'(1) << e.id);
      chk({tag, " edge"}, 32'(cyc), 32'(e.at));
      chk({tag, " gnt"}, 32'(gnt), 32'(1) << e.id);
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         chk("gnt onehot", 32'($countones(gnt) <= 1), 32'(1));
         chk("done in gnt", 32'(done & ~gnt), 32'(0));
      end
   end

   initial begin
      step();
      step();
      chk("rst gnt", 32'(gnt), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst count", 32'(count), 32'(0));
      rst = 1'b0;
      // single request, length change after load must be ignored
      set_len(2, 5);
      req = 4'b0100;
      step();
      chk("single gnt", 32'(gnt), 32'(4'b0100));
      chk("single id", 32'(active_id), 32'(2));
      chk("single busy", 32'(busy), 32'(1));
      sb.push_back('{id: 2, at: cyc + 7});
      for (int v = 5; v >= 0; v--) begin
         step();
         chk("single count", 32'(count), 32'(v));
         chk("single no done", 32'(done), 32'(0));
         if (v == 5) set_len(2, 99);
      end
      wait_done("single");
      req = '0;
      step();
      chk("single gnt off", 32'(gnt), 32'(0));
      chk("single idle", 32'(busy), 32'(0));
      // zero length
      set_len(1, 0);
      req = 4'b0010;
      step();
      sb.push_back('{id: 1, at: cyc + 2});
      wait_done("zero");
      chk("zero busy", 32'(busy), 32'(1));
      req = '0;
      step();
      chk("zero idle", 32'(busy), 32'(0));
      // asynchronous reset mid-countdown
      set_len(1, 9);
      req = 4'b0010;
      step();
      for (int k = 0; k < 6; k++) step();
      chk("pre-rst count", 32'(count), 32'(4));
      #2 rst = 1'b1;
      #1;
      chk("arst gnt", 32'(gnt), 32'(0));
      chk("arst done", 32'(done), 32'(0));
      chk("arst busy", 32'(busy), 32'(0));
      chk("arst count", 32'(count), 32'(0));
      chk("arst id", 32'(active_id), 32'(0));
      step();
      // round robin after reset: pointer restarts so requester 0 wins
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_len(i, 1);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) sb.push_back('{id: k % 4, at: cyc + 4 + 5*k});
      for (int k = 0; k < 5; k++) wait_done("rr");
      req = '0;
      step();
      step();
      chk("rr idle", 32'(busy), 32'(0));
      // abort
      set_len(3, 20);
      set_len(0, 2);
      req = 4'b1000;
      step();
      chk("abort gnt", 32'(gnt), 32'(4'b1000));
      for (int k = 0; k < 9; k++) step();
      chk("abort count", 32'(count), 32'(12));
      req = 4'b0001;
      step();
      chk("abort gnt off", 32'(gnt), 32'(0));
      chk("abort busy", 32'(busy), 32'(0));
      chk("abort hold cnt", 32'(count), 32'(12));
      chk("abort no done", 32'(done), 32'(0));
      step();
      chk("after abort gnt", 32'(gnt), 32'(4'b0001));
      sb.push_back('{id: 0, at: cyc + 4});
      wait_done("after abort");
      req = '0;
      step();
      step();
`ifdef SHARED_TIMER_HOLD_EN
      set_len(2, 6);
      req = 4'b0100;
      step();
      sb.push_back('{id: 2, at: cyc + 11});
      for (int k = 0; k < 4; k++) step();
      chk("hold pre", 32'(count), 32'(3));
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold frozen", 32'(count), 32'(3));
      end
      hold = 1'b0;
      wait_done("hold");
      req = '0;
      step();
      step();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/shared_timer_arbiter.md
Name: shared_timer_arbiter

Overview:
Round-robin scheduler that shares one down-counting delay timer between NREQ requesters.
- Each requester asks for a one-shot delay of its own length.
- The arbiter grants the timer to one requester at a time, loads that requester's length, sequences the countdown, and returns a one-cycle done pulse.
- Sits between control FSMs needing programmable waits and a single counter resource in the LibFPGA counter family.

Parameters:
WIDTH, 8, bit width of delay length and internal counter
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), width of active_id (derived localparam, not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  request per requester; level, held until done or abandoned
req_len  in  NREQ*WIDTH  delay length per requester, slice i = [i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot grant, registered
done  out  NREQ  one-cycle completion pulse to granted requester, registered
busy  out  1  high whenever state != IDLE
active_id  out  IDW  index of granted requester (valid while busy)
count  out  WIDTH  current internal counter value

Behaviour:
- Reset: asynchronous, active-high. While rst is high, force state=IDLE, gnt=0, done=0, busy=0, active_id=0, count=0, rr pointer=NREQ-1 (so req[0] wins first). Applies immediately, including mid-operation; the interrupted requester gets no done.
- FSM states:
  - IDLE: if any req is high at an edge, pick the winner round-robin: first set bit searching from pointer+1 upward with wrap to 0. Set gnt[winner], active_id, pointer=winner; go to LOAD. No req: stay.
  - LOAD: latch count <= req_len[active_id], sampled at this edge; go to COUNT.
  - COUNT: if count==0, go to DONE; else count <= count-1.
  - DONE: done[active_id]=1 for this cycle only; clear gnt; go to IDLE.
- Latency: req sampled in IDLE at edge t with length L:
  - gnt high from edge t to edge t+L+3.
  - done high between edges t+L+2 and t+L+3.
  - L=0 is legal: done between t+2 and t+3.
  - Earliest next grant is edge t+L+4.
- Abort: if req[active_id] is low at an edge while in LOAD or COUNT, go to IDLE, clear gnt, no done; count holds its value; pointer stays at the aborted index, so it rotates past it.
- req_len changes after the LOAD edge are ignored.
- Requests from non-granted requesters are never lost while held; they are arbitrated at the next IDLE edge.
- A requester keeping req high after done is re-queued with the lowest priority (round-robin fairness).
- Wrap-around: the counter never underflows; COUNT exits at 0. L=2^WIDTH-1 gives the maximum delay.
- gnt is always zero or one-hot; done is always a subset of gnt.

Optional Feature:
SHARED_TIMER_HOLD_EN
- Defined: adds input port hold (1 bit, after req_len). While hold=1 in COUNT, count and state freeze. An abort via req low still takes effect. LOAD and DONE are not affected by hold.
- Undefined: no hold port; COUNT always decrements.

Test Plan:
- Reset: assert rst mid-COUNT (L=9, count=4) -> gnt, done, busy, count, active_id all 0 asynchronously; after release with req[0]=1 -> req[0] granted first.
- Single request: req[2]=1, len=5, sampled at edge 10 -> gnt=4'b0100 edges 10-18; done[2] only between edges 17 and 18; count sequence 5,4,3,2,1,0.
- Zero length: req[1]=1, len=0 at edge t -> done[1] between edges t+2 and t+3, busy falls at edge t+3.
- Round-robin: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0; each grant followed by exactly one done; no two gnt bits ever high.
- Abort: req[3] len=20 granted, drop req[3] at count=12 -> IDLE next edge, no done[3]; pending req[0] granted at the following edge.
- Hold (SHARED_TIMER_HOLD_EN): len=6, hold=1 for 3 cycles at count=3 -> count stays 3 during hold; done delayed by exactly 3 cycles versus the no-hold run.
